mic_sample_stream: RTL
======================

# mic_sample_stream

Parametrised microphone sample capture stage between `pdm_filter` and downstream audio consumers (record buffer, FFT, bus slave). Detects rising edges of the filter's sample strobe and decimates them by a runtime ratio. Applies a saturating gain to each kept sample and queues it in a FIFO drained through a valid/ready stream. Replaces the fixed divide-by-2, no-backpressure capture path.

## Interface

- `DATA_W`, 16: sample width, two's complement.
- `DECIM_W`, 4: width of the decimation ratio input.
- `FIFO_DEPTH`, 16: FIFO entries; power of 2, at least 2.
- `clk_i`  in  1  system clock (100 MHz).
- `rst_n_i`  in  1  reset, synchronous, active-low. One clock; all state is reset on the rising edge of `clk_i` while `rst_n_i`=0.
- `enable_i`  in  1  capture enable.
- `fs_i`  in  1  sample strobe from `pdm_filter`, synchronous to `clk_i`.
- `data_i`  in  DATA_W  filter sample; valid while `fs_i` is high.
- `decim_i`  in  DECIM_W  decimation ratio N; 0 is treated as 1.
- `shift_i`  in  3  gain as a left shift of 0..7 bits, saturating.
- `clear_ovf_i`  in  1  clears `overflow_o`.
- `m_valid_o`  out  1  FIFO head valid.
- `m_ready_i`  in  1  consumer accepts the head.
- `m_data_o`  out  DATA_W  FIFO head sample.
- `fill_o`  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
- `overflow_o`  out  1  sticky flag: a sample was dropped.

## Operation

- **Edge detect.** `fs_q1 <= fs_i` and `fs_q2 <= fs_q1`. The combinational `rise = fs_q1 & ~fs_q2`. A level held high yields exactly one rise.
- **Decimation counter.** The counter `cnt` runs over 0..N-1.
  - On a rise with `enable_i`=1: if `cnt >= N-1`, the sample is selected and `cnt <= 0`; otherwise `cnt <= cnt+1`.
  - Because of the `>=` test, lowering N mid-stream takes effect at the next rise.
  - While `enable_i`=0, `cnt <= 0` and no samples are selected.
- **Gain.** On a select, `data_i` is shifted left by `shift_i`. The result saturates to the max or min signed `DATA_W` value, e.g. 0x7FFF or 0x8000 at 16 bits. The result is registered in the stage register `stg` with `stg_v` = 1 for one cycle.
- **FIFO push.** `stg_v` pushes `stg`. The FIFO is show-ahead: `m_data_o` is the head whenever `m_valid_o`=1.
- **FIFO pop.** A pop occurs when `m_valid_o && m_ready_i`.
- **Push and pop in the same cycle.**
  - Both are performed and the count is unchanged.
  - This holds when full as well: the pop frees the slot and the push is accepted.
- **Overflow.** A push when full without a pop drops the sample, sets `overflow_o`, and leaves the FIFO unchanged.
- **Overflow clear.** `clear_ovf_i`=1 clears `overflow_o`. A new overflow in the same cycle wins, so the flag stays 1.
- **Dynamic inputs.** `enable_i` deassertion does not flush the FIFO; draining continues. `shift_i` and `decim_i` may change at any time and are sampled at the select cycle.
- **Reset values.** `m_valid_o`=0, `m_data_o`=0, `fill_o`=0, `overflow_o`=0. Internally: `cnt`=0, `fs_q1`=`fs_q2`=0, `stg_v`=0, and the FIFO pointers are 0.
- **Reset mid-stream.** Reset discards FIFO contents and any in-flight `stg`. `fs_q` is also cleared, so `fs_i` held high across reset release produces a rise on the second edge after release.

## Timing

- Let E be the first `clk_i` edge sampling `fs_i`=1 after a 0.
- `rise` is high between E and E+1. The counter update and the `stg` capture of `data_i` happen at E+1, so `data_i` must be stable across E..E+1.
- The FIFO write happens at E+2. With the FIFO empty, `m_valid_o`=1 and `m_data_o` equals the sample after E+2, which is 2 cycles after the rise.
- With `MIC_DC_BLOCK_EN`, there is one extra stage: `m_valid_o` rises after E+3.
- `fill_o` and `overflow_o` update on the same edge as the FIFO write or pop.
- Throughput is one sample per `fs_i` period. Consecutive rises at least 2 cycles apart must be handled.

## Configuration

- **Macro:** `MIC_DC_BLOCK_EN`.
- **Defined:** a DC-removal stage sits between selection and gain, with latency +1 cycle.
  - The accumulator `acc` is `DATA_W+8` bits signed, reset to 0.
  - `dc = acc >>> 8` (arithmetic shift).
  - `y = sat(x - dc)`.
  - `acc <= acc + (x - dc)`, updated only on selected samples.
  - The gain is applied to `y`.
- **Undefined:** no accumulator is instantiated; samples go straight from selection to gain.

## Test plan

- **Basic ratio:** N=2, shift=0, fs pulses every 20 cycles with data 0x0010, 0x0020, 0x0030, 0x0040 → FIFO receives 0x0020 and 0x0040. `m_valid_o` rises 2 cycles after the 2nd rise.
- **N=0 and N=1, dynamic change:** N=0 and N=1 pass every sample. Change N from 5 to 1 while `cnt`=3 → the next rise selects.
- **Saturation:** shift=3 with data 0x1234 → 0x7FFF; shift=3 with 0xF000 → 0x8000; shift=2 with 0x0101 → 0x0404.
- **Backpressure, full, overflow:** `m_ready_i`=0 for 17 selected samples at DEPTH=16 → `fill_o`=16, `overflow_o`=1, head is the first sample.
  - Push and pop in the same cycle while full → `fill_o` stays 16 and no new overflow.
  - `clear_ovf_i` pulse → `overflow_o`=0.
- **Reset mid-stream:** `rst_n_i`=0 for 1 cycle with `fill_o`=5 → all outputs 0 next cycle, and the subsequent decimation phase restarts from `cnt`=0.
- **DC block (`MIC_DC_BLOCK_EN` defined):** constant input 0x0400 with N=1 → first output 0x0400, outputs decaying toward 0. The 2000th output has magnitude below 0x0010.

Source files
------------

// File: rtl/mic_sample_stream.sv
`default_nettype none
// ============================================================================
// Module   : mic_sample_stream
// Purpose  : Strobe rise detect, runtime decimation, saturating gain and a
//            show-ahead FIFO drained over valid/ready.
//            Defining MIC_DC_BLOCK_EN inserts a DC-removal stage before gain.
// Revision : 1.0  initial release
// ============================================================================
module mic_sample_stream #(
  parameter int DATA_W     = 16,
  parameter int DECIM_W    = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        enable_i,
  input  logic                        fs_i,
  input  logic [DATA_W-1:0]           data_i,
  input  logic [DECIM_W-1:0]          decim_i,
  input  logic [2:0]                  shift_i,
  input  logic                        clear_ovf_i,
  output logic                        m_valid_o,
  input  logic                        m_ready_i,
  output logic [DATA_W-1:0]           m_data_o,
  output logic [$clog2(FIFO_DEPTH):0] fill_o,
  output logic                        overflow_o
);

  localparam int                 c_ADDR_W = $clog2(FIFO_DEPTH);
  localparam logic [c_ADDR_W:0]  c_FULL   = (c_ADDR_W+1)'(FIFO_DEPTH);
  localparam logic [DATA_W-1:0]  c_MAX    = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0]  c_MIN    = {1'b1, {(DATA_W-1){1'b0}}};

  // The value fits in DATA_W bits only if the bits from the new sign position
  // upward are all equal; otherwise clamp by the preserved sign.
  function automatic logic [DATA_W-1:0] gain_sat(input logic [DATA_W-1:0] x,
                                                 input logic [2:0]        sh);
    logic [DATA_W+6:0] wide;
    wide = {{7{x[DATA_W-1]}}, x} << sh;
    if ((&wide[DATA_W+6:DATA_W-1]) || (~|wide[DATA_W+6:DATA_W-1]))
      return wide[DATA_W-1:0];
    return wide[DATA_W+6] ? c_MIN : c_MAX;
  endfunction

  // ---------------------------------------------------------------- select
  logic               r_fs_q1;
  logic               r_fs_q2;
  logic               w_rise;
  logic [DECIM_W-1:0] r_cnt;
  logic [DECIM_W-1:0] w_n_m1;
  logic               w_sel;

  assign w_rise = r_fs_q1 & ~r_fs_q2;
  assign w_n_m1 = (decim_i == '0) ? '0 : decim_i - DECIM_W'(1);
  assign w_sel  = w_rise & enable_i & (r_cnt >= w_n_m1);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_fs_q1 <= 1'b0;
      r_fs_q2 <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_fs_q1 <= fs_i;
      r_fs_q2 <= r_fs_q1;
      if (!enable_i)
        r_cnt <= '0;
      else if (w_rise)
        r_cnt <= (r_cnt >= w_n_m1) ? '0 : r_cnt + DECIM_W'(1);
    end
  end

  // ---------------------------------------------------------- gain source
  logic              w_g_v;
  logic [DATA_W-1:0] w_g_x;
  logic [2:0]        w_g_sh;

`ifdef MIC_DC_BLOCK_EN
  logic [DATA_W+7:0] r_acc;
  logic [DATA_W-1:0] r_dc_x;
  logic [2:0]        r_dc_sh;
  logic              r_dc_v;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W-1:0] w_y;

  // acc[DATA_W+7:8] is acc >>> 8 truncated to the sample width
  assign w_diff = {r_dc_x[DATA_W-1], r_dc_x} - {r_acc[DATA_W+7], r_acc[DATA_W+7:8]};
  assign w_y    = (w_diff[DATA_W] == w_diff[DATA_W-1]) ? w_diff[DATA_W-1:0]
                : (w_diff[DATA_W] ? c_MIN : c_MAX);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_acc   <= '0;
      r_dc_x  <= '0;
      r_dc_sh <= '0;
      r_dc_v  <= 1'b0;
    end else begin
      r_dc_v <= w_sel;
      if (w_sel) begin
        r_dc_x  <= data_i;
        r_dc_sh <= shift_i;
      end
      if (r_dc_v)
        r_acc <= r_acc + {{7{w_diff[DATA_W]}}, w_diff};
    end
  end

  assign w_g_v  = r_dc_v;
  assign w_g_x  = w_y;
  assign w_g_sh = r_dc_sh;
`else
  assign w_g_v  = w_sel;
  assign w_g_x  = data_i;
  assign w_g_sh = shift_i;
`endif

  // ---------------------------------------------------------- stage reg
  logic              r_stg_v;
  logic [DATA_W-1:0] r_stg;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_stg_v <= 1'b0;
      r_stg   <= '0;
    end else begin
      r_stg_v <= w_g_v;
      if (w_g_v)
        r_stg <= gain_sat(w_g_x, w_g_sh);
    end
  end

  // ---------------------------------------------------------------- FIFO
  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [c_ADDR_W-1:0] r_wr_ptr;
  logic [c_ADDR_W-1:0] r_rd_ptr;
  logic [c_ADDR_W:0]   r_count;
  logic                r_ovf;
  logic                w_full;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;

  // A pop frees the slot for a same-cycle push even when full
  assign w_full = (r_count == c_FULL);
  assign w_pop  = m_valid_o & m_ready_i;
  assign w_push = r_stg_v & (~w_full | w_pop);
  assign w_drop = r_stg_v & w_full & ~w_pop;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= r_stg;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_ADDR_W+1)'(1);
        2'b01:   r_count <= r_count - (c_ADDR_W+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop)
        r_ovf <= 1'b1;
      else if (clear_ovf_i)
        r_ovf <= 1'b0;
    end
  end

  assign m_valid_o  = (r_count != '0);
  assign m_data_o   = m_valid_o ? r_mem[r_rd_ptr] : '0;
  assign fill_o     = r_count;
  assign overflow_o = r_ovf;

endmodule
`default_nettype wire
